// File: rtl/plc_pkg.sv
// Shared plant/PLC definitions: pump state encoding and level widths.
package plc_pkg;

  localparam int unsigned LVL_W   = 8;
  localparam int unsigned LVL_MAX = 255;
  localparam int unsigned NET_W   = 11;

  typedef enum logic [1:0] {
    PUMP_OFF      = 2'd0,
    PUMP_STARTING = 2'd1,
    PUMP_RUN      = 2'd2,
    PUMP_STOPPING = 2'd3
  } pump_state_e;

endpackage

// File: rtl/pump_actuator.sv
// One pump actuator: start/stop delay FSM advanced on plant ticks, with a registered flow contribution.
module pump_actuator
  import plc_pkg::*;
#(
  parameter int unsigned START_DLY = 5,
  parameter int unsigned STOP_DLY  = 3,
  parameter int unsigned FLOW      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             cmd_i,
  output logic             run_o,
  output logic [LVL_W-1:0] flow_o
);

  localparam int unsigned DLY_MAX = (START_DLY > STOP_DLY) ? START_DLY : STOP_DLY;
  localparam int unsigned TMR_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam logic [LVL_W-1:0] FLOW_RUN  = LVL_W'(FLOW);
  localparam logic [LVL_W-1:0] FLOW_STOP = LVL_W'(FLOW >> 1);

  pump_state_e      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             run_q, run_d;
  logic [LVL_W-1:0] flow_q, flow_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PUMP_OFF;
      tmr_q   <= '0;
      run_q   <= 1'b0;
      flow_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      run_q   <= run_d;
      flow_q  <= flow_d;
    end
  end

  // Next state; run/flow follow the state that will hold after this cycle.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    run_d   = 1'b0;
    flow_d  = '0;
    if (tick_i) begin
      unique case (state_q)
        PUMP_OFF: begin
          if (cmd_i) begin
            state_d = PUMP_STARTING;
            tmr_d   = TMR_W'(START_DLY - 1);
          end
        end
        PUMP_STARTING: begin
          if (!cmd_i)              state_d = PUMP_OFF;
          else if (tmr_q == '0)    state_d = PUMP_RUN;
          else                     tmr_d   = tmr_q - TMR_W'(1);
        end
        PUMP_RUN: begin
          if (!cmd_i) begin
            state_d = PUMP_STOPPING;
            tmr_d   = TMR_W'(STOP_DLY - 1);
          end
        end
        PUMP_STOPPING: begin
          if (tmr_q == '0) state_d = PUMP_OFF;
          else             tmr_d   = tmr_q - TMR_W'(1);
        end
        default: state_d = PUMP_OFF;
      endcase
    end
    unique case (state_d)
      PUMP_RUN:      flow_d = FLOW_RUN;
      PUMP_STOPPING: flow_d = FLOW_STOP;
      default:       flow_d = '0;
    endcase
    run_d = (state_d == PUMP_RUN);
  end

  assign run_o  = run_q;
  assign flow_o = flow_q;

endmodule

// File: rtl/tank_plant_model.sv
// Tank plant: tick prescaler, two pump actuators and a saturating level integrator with trend/flags.
module tank_plant_model
  import plc_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 10_000_000,
  parameter int unsigned START_DLY = 5,
  parameter int unsigned STOP_DLY  = 3,
  parameter int unsigned P1_FLOW   = 4,
  parameter int unsigned P2_FLOW   = 6,
  parameter int unsigned DRAIN     = 3,
  parameter int unsigned INIT_LVL  = 128
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             pump1_cmd,
  input  logic             pump2_cmd,
  output logic [LVL_W-1:0] water_lvl,
  output logic             water_trend,
  output logic             pump1_run,
  output logic             pump2_run,
  output logic             full_flag,
  output logic             empty_flag
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic signed [NET_W-1:0] NET_MAX = NET_W'(LVL_MAX);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LVL_W-1:0]        lvl_q, lvl_d;
  logic                    trend_q, trend_d;
  logic                    full_q, full_d;
  logic                    empty_q, empty_d;
  logic                    tick_c;
  logic [LVL_W-1:0]        flow1_c, flow2_c;
  logic signed [NET_W-1:0] net_c;

  pump_actuator #(.START_DLY(START_DLY), .STOP_DLY(STOP_DLY), .FLOW(P1_FLOW)) u_pump1 (
    .clk    (CLK100MHZ),
    .rst_n  (CPU_RESETN),
    .tick_i (tick_c),
    .cmd_i  (pump1_cmd),
    .run_o  (pump1_run),
    .flow_o (flow1_c)
  );

  pump_actuator #(.START_DLY(START_DLY), .STOP_DLY(STOP_DLY), .FLOW(P2_FLOW)) u_pump2 (
    .clk    (CLK100MHZ),
    .rst_n  (CPU_RESETN),
    .tick_i (tick_c),
    .cmd_i  (pump2_cmd),
    .run_o  (pump2_run),
    .flow_o (flow2_c)
  );

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt_q   <= '0;
      lvl_q   <= LVL_W'(INIT_LVL);
      trend_q <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      trend_q <= trend_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign tick_c = (cnt_q == CNT_LAST);

  // Signed net level is wide enough that overflow and underflow never wrap.
  always_comb begin
    cnt_d   = tick_c ? '0 : cnt_q + CNT_W'(1);
    lvl_d   = lvl_q;
    trend_d = trend_q;
    full_d  = full_q;
    empty_d = empty_q;
    net_c   = $signed(NET_W'(lvl_q)) + $signed(NET_W'(flow1_c)) + $signed(NET_W'(flow2_c))
            - $signed(NET_W'(DRAIN));
    if (tick_c) begin
      full_d  = 1'b0;
      empty_d = 1'b0;
      if (net_c > NET_MAX) begin
        lvl_d  = LVL_W'(LVL_MAX);
        full_d = 1'b1;
      end else if (net_c[NET_W-1]) begin
        lvl_d   = '0;
        empty_d = 1'b1;
      end else begin
        lvl_d = net_c[LVL_W-1:0];
      end
      trend_d = (lvl_d > lvl_q);
    end
  end

  assign water_lvl   = lvl_q;
  assign water_trend = trend_q;
  assign full_flag   = full_q;
  assign empty_flag  = empty_q;

endmodule

// File: tb/tb_tank_plant_model.sv
// Bench for tank_plant_model: tick-level behavioural model checked every cycle, plus pinned literal levels.
module tb_tank_plant_model;

  localparam int TD    = 4;
  localparam int SDLY  = 2;
  localparam int PDLY  = 2;
  localparam int F1    = 4;
  localparam int F2    = 6;
  localparam int DRN   = 3;
  localparam int INITL = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p1_cmd = 1'b0;
  logic       p2_cmd = 1'b0;
  logic [7:0] lvl;
  logic       trend, run1, run2, full, empty;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  tank_plant_model #(
    .TICK_DIV(TD), .START_DLY(SDLY), .STOP_DLY(PDLY),
    .P1_FLOW(F1), .P2_FLOW(F2), .DRAIN(DRN), .INIT_LVL(INITL)
  ) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .pump1_cmd   (p1_cmd),
    .pump2_cmd   (p2_cmd),
    .water_lvl   (lvl),
    .water_trend (trend),
    .pump1_run   (run1),
    .pump2_run   (run2),
    .full_flag   (full),
    .empty_flag  (empty)
  );

  // Model: phase 0=off 1=starting 2=running 3=coasting; m_el = ticks already spent in phase.
  int m_ph[2];
  int m_el[2];
  int m_lvl;
  int m_trend, m_full, m_empty;
  int m_edge;

  function automatic int flow_of(input int ph, input int f);
    if (ph == 2) return f;
    if (ph == 3) return f / 2;
    return 0;
  endfunction

  task automatic advance(input int idx, input bit cmd);
    case (m_ph[idx])
      0: if (cmd) begin m_ph[idx] = 1; m_el[idx] = 0; end
      1: begin
        if (!cmd) m_ph[idx] = 0;
        else if (m_el[idx] == SDLY - 1) m_ph[idx] = 2;
        else m_el[idx]++;
      end
      2: if (!cmd) begin m_ph[idx] = 3; m_el[idx] = 0; end
      default: begin
        if (m_el[idx] == PDLY - 1) m_ph[idx] = 0;
        else m_el[idx]++;
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph[0] = 0; m_ph[1] = 0; m_el[0] = 0; m_el[1] = 0;
      m_lvl = INITL; m_trend = 0; m_full = 0; m_empty = 0; m_edge = 0;
    end else begin
      m_edge++;
      if (m_edge % TD == 0) begin
        int net, nl;
        net = m_lvl + flow_of(m_ph[0], F1) + flow_of(m_ph[1], F2) - DRN;
        nl = (net > 255) ? 255 : (net < 0) ? 0 : net;
        m_full  = (net > 255) ? 1 : 0;
        m_empty = (net < 0) ? 1 : 0;
        m_trend = (nl > m_lvl) ? 1 : 0;
        m_lvl   = nl;
        advance(0, p1_cmd);
        advance(1, p2_cmd);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample at the falling edge and compare every output to the model.
  task automatic step();
    @(negedge clk);
    check("lvl", int'(lvl), m_lvl);
    check("trend", int'(trend), m_trend);
    check("run1", int'(run1), (m_ph[0] == 2) ? 1 : 0);
    check("run2", int'(run2), (m_ph[1] == 2) ? 1 : 0);
    check("full", int'(full), m_full);
    check("empty", int'(empty), m_empty);
  endtask

  task automatic run_ticks(input int n);
    repeat (n * TD) step();
  endtask

  task automatic pin(input string name, input int l, input int tr, input int r1, input int r2,
                     input int fu, input int em);
    check({name, ".lvl"}, int'(lvl), l);
    check({name, ".trend"}, int'(trend), tr);
    check({name, ".run1"}, int'(run1), r1);
    check({name, ".run2"}, int'(run2), r2);
    check({name, ".full"}, int'(full), fu);
    check({name, ".empty"}, int'(empty), em);
  endtask

  initial begin
    repeat (3) step();
    pin("reset", 128, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    run_ticks(10);
    pin("idle10", 98, 0, 0, 0, 0, 0);

    p1_cmd = 1'b1;
    run_ticks(2);
    pin("p1_start2", 92, 0, 0, 0, 0, 0);
    run_ticks(1);
    pin("p1_run", 89, 0, 1, 0, 0, 0);
    run_ticks(1);
    pin("p1_gain", 90, 1, 1, 0, 0, 0);

    p1_cmd = 1'b0;
    run_ticks(1);
    pin("p1_drop", 91, 1, 0, 0, 0, 0);
    run_ticks(2);
    pin("p1_coast", 89, 0, 0, 0, 0, 0);
    run_ticks(1);
    pin("p1_off", 86, 0, 0, 0, 0, 0);

    p1_cmd = 1'b1; p2_cmd = 1'b1;
    run_ticks(40);
    pin("full_hold", 255, 0, 1, 1, 1, 0);

    p1_cmd = 1'b0; p2_cmd = 1'b0;
    run_ticks(10);
    pin("wind_down", 234, 0, 0, 0, 0, 0);

    p2_cmd = 1'b1;
    run_ticks(1);
    p2_cmd = 1'b0;
    pin("p2_pulse", 231, 0, 0, 0, 0, 0);
    run_ticks(1);
    pin("p2_pulse_off", 228, 0, 0, 0, 0, 0);

    run_ticks(90);
    pin("empty_hold", 0, 0, 0, 0, 0, 1);

    // Random commands held for random spans, with invisible mid-tick glitches.
    for (int t = 0; t < 300; ) begin
      int span;
      span = int'($urandom_range(1, 12));
      p1_cmd = 1'($urandom_range(0, 1));
      p2_cmd = 1'($urandom_range(0, 1));
      for (int k = 0; k < span; k++) begin
        bit g1, g2;
        g1 = 1'($urandom_range(0, 1));
        g2 = 1'($urandom_range(0, 1));
        step();
        if (g1) p1_cmd = ~p1_cmd;
        if (g2) p2_cmd = ~p2_cmd;
        step();
        if (g1) p1_cmd = ~p1_cmd;
        if (g2) p2_cmd = ~p2_cmd;
        step();
        step();
      end
      t += span;
    end

    p1_cmd = 1'b1; p2_cmd = 1'b1;
    run_ticks(10);
    check("pre_reset.run1", int'(run1), 1);
    check("pre_reset.run2", int'(run2), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 pin("async_reset", 128, 0, 0, 0, 0, 0);
    p1_cmd = 1'b0; p2_cmd = 1'b0;
    step();
    rst_n = 1'b1;
    run_ticks(1);
    pin("after_reset", 125, 0, 0, 0, 0, 0);
    run_ticks(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
